// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the demux_seq channel demultiplexer.
//   NUM_CH : number of output channels
//   sel_t  : channel index type
//   next_ch: round-robin successor of a channel index (wraps 3 -> 0)
package demux_pkg;
    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    function automatic sel_t next_ch(input sel_t ch);
        return ch + 2'd1;
    endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register for a single demux channel.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q and valid
//   load  : capture d this edge (wins over a simultaneous drain)
//   d     : incoming data word
//   q     : held data word, stable while valid=1 and ready=0
//   valid : q holds a word
//   ready : consumer takes q this edge
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid,
    input  logic         ready
);
    // A load on the same edge as a drain keeps valid set so a full slot
    // can stream one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux_seq.sv
// demux_seq: 1-to-4 valid/ready demultiplexer with manual or round-robin select.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   x       : input data word
//   x_valid : x offered for transfer
//   x_ready : target channel can accept x this cycle
//   c0, c1  : manual channel select, channel = {c1,c0}
//   rr      : 1 = round-robin target, 0 = manual target
//   m0..m3  : per-channel output words
//   m_valid : per-channel word-present flags
//   m_ready : per-channel consumer-takes-word strobes
module demux_seq
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      x,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic              c0,
    input  logic              c1,
    input  logic              rr,
    output logic [W-1:0]      m0,
    output logic [W-1:0]      m1,
    output logic [W-1:0]      m2,
    output logic [W-1:0]      m3,
    output logic [NUM_CH-1:0] m_valid,
    input  logic [NUM_CH-1:0] m_ready
);
    sel_t              target;
    sel_t              rr_ptr;
    logic              xfer;
    logic [NUM_CH-1:0] load;
    logic [W-1:0]      q [NUM_CH];

    // Select is not registered: mode and manual select act in the same cycle.
    always_comb target = rr ? rr_ptr : {c1, c0};

    // Only the target channel gates acceptance, so a blocked target stalls
    // the input even when other channels are free.
    assign x_ready = !m_valid[target] | m_ready[target];
    assign xfer    = x_valid & x_ready;

    // Pointer moves only on a round-robin transfer and is held otherwise,
    // so returning to round-robin resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (xfer && rr)
            rr_ptr <= next_ch(rr_ptr);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_slot
        assign load[g] = xfer && (target == sel_t'(g));
        demux_slot #(.W(W)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[g]),
            .d     (x),
            .q     (q[g]),
            .valid (m_valid[g]),
            .ready (m_ready[g])
        );
    end

    assign m0 = q[0];
    assign m1 = q[1];
    assign m2 = q[2];
    assign m3 = q[3];
endmodule

// File: tb/tb_demux_seq.sv
// tb_demux_seq: directed self-checking bench for demux_seq.
module tb_demux_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] x = '0;
    logic       x_valid = 1'b0;
    logic       x_ready;
    logic       c0 = 1'b0;
    logic       c1 = 1'b0;
    logic       rr = 1'b0;
    logic [7:0] m0, m1, m2, m3;
    logic [3:0] m_valid;
    logic [3:0] m_ready = '0;
    int         n_vec = 0;
    int         n_err = 0;

    demux_seq #(.W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .c0      (c0),
        .c1      (c1),
        .rr      (rr),
        .m0      (m0),
        .m1      (m1),
        .m2      (m2),
        .m3      (m3),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        x_valid = 1'b0;
        m_ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one word in the low phase, check it is accepted, then sample
    // one time unit after the capturing edge.
    task automatic send(input string tag, input logic [7:0] d);
        @(negedge clk);
        x = d;
        x_valid = 1'b1;
        #1 chk({tag, ".rdy"}, x_ready, 1'b1);
        @(posedge clk);
        #1 x_valid = 1'b0;
    endtask

    task automatic sel(input logic [1:0] ch);
        {c1, c0} = ch;
    endtask

    initial begin
        // Reset with x_valid held high: nothing loads, x_ready reads 1.
        rr = 1'b1;
        x = 8'h77;
        x_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.mv", m_valid, 4'b0000);
        chk("rst.m0", m0, 8'h00);
        chk("rst.m1", m1, 8'h00);
        chk("rst.m2", m2, 8'h00);
        chk("rst.m3", m3, 8'h00);
        chk("rst.rdy", x_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        x = 8'h3C;
        #1 chk("rst.rdy_after", x_ready, 1'b1);
        @(posedge clk);
        #1 x_valid = 1'b0;
        chk("rst.first_m0", m0, 8'h3C);
        chk("rst.first_mv", m_valid, 4'b0001);

        // Manual select to channel 2 with all consumers ready.
        do_reset();
        rr = 1'b0;
        sel(2'b10);
        m_ready = 4'b1111;
        send("man", 8'hA5);
        chk("man.m2", m2, 8'hA5);
        chk("man.mv", m_valid, 4'b0100);
        @(posedge clk);
        #1 chk("man.mv_drained", m_valid, 4'b0000);

        // Round-robin over five words wraps back to channel 0.
        do_reset();
        rr = 1'b1;
        m_ready = 4'b1111;
        send("rr1", 8'h01);
        chk("rr1.m0", m0, 8'h01);
        chk("rr1.mv", m_valid, 4'b0001);
        send("rr2", 8'h02);
        chk("rr2.m1", m1, 8'h02);
        chk("rr2.mv", m_valid, 4'b0010);
        send("rr3", 8'h03);
        chk("rr3.m2", m2, 8'h03);
        chk("rr3.mv", m_valid, 4'b0100);
        send("rr4", 8'h04);
        chk("rr4.m3", m3, 8'h04);
        chk("rr4.mv", m_valid, 4'b1000);
        send("rr5", 8'h05);
        chk("rr5.m0", m0, 8'h05);
        chk("rr5.mv", m_valid, 4'b0001);
        send("rr6", 8'h06);
        chk("rr6.m1", m1, 8'h06);
        chk("rr6.mv", m_valid, 4'b0010);

        // Backpressure on channel 3.
        do_reset();
        rr = 1'b0;
        sel(2'b11);
        m_ready = 4'b0000;
        send("bp1", 8'h11);
        chk("bp1.m3", m3, 8'h11);
        chk("bp1.mv", m_valid, 4'b1000);
        @(negedge clk);
        x = 8'h22;
        x_valid = 1'b1;
        #1 chk("bp2.rdy_blocked", x_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("bp2.m3_held", m3, 8'h11);
        chk("bp2.mv_held", m_valid, 4'b1000);
        @(negedge clk);
        sel(2'b00);
        #1 chk("bp.sel_comb", x_ready, 1'b1);
        sel(2'b11);
        #1 chk("bp.sel_back", x_ready, 1'b0);
        m_ready = 4'b1000;
        #1 chk("bp3.rdy", x_ready, 1'b1);
        @(posedge clk);
        #1 x_valid = 1'b0;
        chk("bp3.m3", m3, 8'h22);
        chk("bp3.mv", m_valid, 4'b1000);
        @(posedge clk);
        #1 chk("bp4.mv", m_valid, 4'b0000);

        // Mode switch: rr pointer is held while in manual mode.
        do_reset();
        rr = 1'b1;
        m_ready = 4'b1111;
        send("ms1", 8'hA1);
        chk("ms1.m0", m0, 8'hA1);
        send("ms2", 8'hA2);
        chk("ms2.m1", m1, 8'hA2);
        rr = 1'b0;
        sel(2'b00);
        send("ms3", 8'hB1);
        send("ms4", 8'hB2);
        send("ms5", 8'hB3);
        chk("ms5.m0", m0, 8'hB3);
        chk("ms5.mv", m_valid, 4'b0001);
        rr = 1'b1;
        send("ms6", 8'hC1);
        chk("ms6.m2", m2, 8'hC1);
        chk("ms6.mv", m_valid, 4'b0100);

        // Mid-stream asynchronous reset with channels 0, 1, 3 full.
        do_reset();
        rr = 1'b0;
        m_ready = 4'b0000;
        sel(2'b00);
        send("mr0", 8'hD0);
        sel(2'b01);
        send("mr1", 8'hD1);
        sel(2'b11);
        send("mr3", 8'hD3);
        chk("mr.mv_full", m_valid, 4'b1011);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.mv", m_valid, 4'b0000);
        chk("mr.m0", m0, 8'h00);
        chk("mr.m1", m1, 8'h00);
        chk("mr.m3", m3, 8'h00);
        chk("mr.rdy", x_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        rr = 1'b1;
        send("mr.after", 8'hE7);
        chk("mr.after_m0", m0, 8'hE7);
        chk("mr.after_mv", m_valid, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
